// File: rtl/traffic_light_xing_if.sv
// Request, lamp and debug bundle of the two-approach crossing controller.
// The controller takes the slave side; whatever issues requests takes master.
interface traffic_light_xing_if;
  logic       req_a;
  logic       req_b;
  logic       a_r;
  logic       a_g;
  logic       a_y;
  logic       b_r;
  logic       b_g;
  logic       b_y;
  logic [3:0] phase;
  logic       pend_a;
  logic       pend_b;

  modport master (
    output req_a, req_b,
    input  a_r, a_g, a_y, b_r, b_g, b_y, phase, pend_a, pend_b
  );

  modport slave (
    input  req_a, req_b,
    output a_r, a_g, a_y, b_r, b_g, b_y, phase, pend_a, pend_b
  );
endinterface

// File: rtl/traffic_light_xing.sv
// Two-approach intersection controller: green, blink pairs, yellow and all-red
// per approach, with latched priority requests that cut the opposing green short.
module traffic_light_xing #(
  parameter int CTR_W   = 10,
  parameter int G_CYC   = 512,
  parameter int BL_CYC  = 64,
  parameter int N_BLINK = 2,
  parameter int Y_CYC   = 256,
  parameter int AR_CYC  = 16,
  parameter int MIN_G   = 128
) (
  input logic                 clk,
  input logic                 rst,
  traffic_light_xing_if.slave xing
);

  typedef enum logic [3:0] {
    A_GRN = 4'd0, A_OFF = 4'd1, A_ON = 4'd2, A_YEL = 4'd3, AR_A = 4'd4,
    B_GRN = 4'd5, B_OFF = 4'd6, B_ON = 4'd7, B_YEL = 4'd8, AR_B = 4'd9
  } state_e;

  localparam int BLINK_W = (N_BLINK > 1) ? $clog2(N_BLINK) : 1;

  localparam logic [CTR_W-1:0]   G_LAST     = CTR_W'(G_CYC - 1);
  localparam logic [CTR_W-1:0]   BL_LAST    = CTR_W'(BL_CYC - 1);
  localparam logic [CTR_W-1:0]   Y_LAST     = CTR_W'(Y_CYC - 1);
  localparam logic [CTR_W-1:0]   AR_LAST    = CTR_W'(AR_CYC - 1);
  localparam logic [CTR_W-1:0]   MIN_LAST   = CTR_W'(MIN_G - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'((N_BLINK > 0) ? N_BLINK - 1 : 0);
  localparam state_e             A_AFTER_G  = (N_BLINK == 0) ? A_YEL : A_OFF;
  localparam state_e             B_AFTER_G  = (N_BLINK == 0) ? B_YEL : B_OFF;

  state_e             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               pend_a_q, pend_a_d;
  logic               pend_b_q, pend_b_d;
  logic               adv;
  logic [5:0]         lamps_q;

  // Lamp vector order: {a_r, a_g, a_y, b_r, b_g, b_y}.
  function automatic logic [5:0] lamp_dec(input state_e s);
    return {!(s inside {A_GRN, A_OFF, A_ON, A_YEL}),
            (s == A_GRN) || (s == A_ON),
            (s == A_YEL),
            !(s inside {B_GRN, B_OFF, B_ON, B_YEL}),
            (s == B_GRN) || (s == B_ON),
            (s == B_YEL)};
  endfunction

  always_comb begin
    adv     = 1'b0;
    state_d = state_q;
    blink_d = blink_q;
    unique case (state_q)
      A_GRN: begin
        if (pend_b_q && ctr_q >= MIN_LAST) begin
          adv = 1'b1; state_d = A_YEL;
        end else if (ctr_q == G_LAST) begin
          adv = 1'b1; state_d = A_AFTER_G;
        end
      end
      A_OFF: begin
        if (pend_b_q) begin
          adv = 1'b1; state_d = A_YEL; blink_d = '0;
        end else if (ctr_q == BL_LAST) begin
          adv = 1'b1; state_d = A_ON;
        end
      end
      A_ON: begin
        if (pend_b_q || (ctr_q == BL_LAST && blink_q == BLINK_LAST)) begin
          adv = 1'b1; state_d = A_YEL; blink_d = '0;
        end else if (ctr_q == BL_LAST) begin
          adv = 1'b1; state_d = A_OFF; blink_d = blink_q + 1'b1;
        end
      end
      A_YEL: if (ctr_q == Y_LAST)  begin adv = 1'b1; state_d = AR_A;  end
      AR_A:  if (ctr_q == AR_LAST) begin adv = 1'b1; state_d = B_GRN; end
      B_GRN: begin
        if (pend_a_q && ctr_q >= MIN_LAST) begin
          adv = 1'b1; state_d = B_YEL;
        end else if (ctr_q == G_LAST) begin
          adv = 1'b1; state_d = B_AFTER_G;
        end
      end
      B_OFF: begin
        if (pend_a_q) begin
          adv = 1'b1; state_d = B_YEL; blink_d = '0;
        end else if (ctr_q == BL_LAST) begin
          adv = 1'b1; state_d = B_ON;
        end
      end
      B_ON: begin
        if (pend_a_q || (ctr_q == BL_LAST && blink_q == BLINK_LAST)) begin
          adv = 1'b1; state_d = B_YEL; blink_d = '0;
        end else if (ctr_q == BL_LAST) begin
          adv = 1'b1; state_d = B_OFF; blink_d = blink_q + 1'b1;
        end
      end
      B_YEL: if (ctr_q == Y_LAST)  begin adv = 1'b1; state_d = AR_B;  end
      AR_B:  if (ctr_q == AR_LAST) begin adv = 1'b1; state_d = A_GRN; end
      default: begin
        adv = 1'b1; state_d = A_GRN; blink_d = '0;
      end
    endcase

    ctr_d = adv ? '0 : ctr_q + 1'b1;

    // A request from an approach that already holds green is ignored; entering green clears it.
    pend_a_d = pend_a_q | (xing.req_a & !(state_q inside {A_GRN, A_OFF, A_ON}));
    pend_b_d = pend_b_q | (xing.req_b & !(state_q inside {B_GRN, B_OFF, B_ON}));
    if (adv && state_d == A_GRN) pend_a_d = 1'b0;
    if (adv && state_d == B_GRN) pend_b_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= A_GRN;
      ctr_q    <= '0;
      blink_q  <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      lamps_q  <= lamp_dec(A_GRN);
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      blink_q  <= blink_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      lamps_q  <= lamp_dec(state_d);
    end
  end

  assign {xing.a_r, xing.a_g, xing.a_y, xing.b_r, xing.b_g, xing.b_y} = lamps_q;
  assign xing.phase  = state_q;
  assign xing.pend_a = pend_a_q;
  assign xing.pend_b = pend_b_q;

endmodule
